// File: rtl/video_timing_pkg.sv
// Shared raster constants for the HDMI output path: 1080p60 and 720p60 timings,
// sync polarities and the background colour used by the display blocks.
package video_timing_pkg;

    localparam int unsigned H_SYNC_1080  = 44;
    localparam int unsigned H_BACK_1080  = 148;
    localparam int unsigned H_DISP_1080  = 1920;
    localparam int unsigned H_FRONT_1080 = 88;
    localparam int unsigned V_SYNC_1080  = 5;
    localparam int unsigned V_BACK_1080  = 36;
    localparam int unsigned V_DISP_1080  = 1080;
    localparam int unsigned V_FRONT_1080 = 4;

    localparam int unsigned H_SYNC_720   = 40;
    localparam int unsigned H_BACK_720   = 220;
    localparam int unsigned H_DISP_720   = 1280;
    localparam int unsigned H_FRONT_720  = 110;
    localparam int unsigned V_SYNC_720   = 5;
    localparam int unsigned V_BACK_720   = 20;
    localparam int unsigned V_DISP_720   = 720;
    localparam int unsigned V_FRONT_720  = 5;

    localparam logic POL_POS = 1'b1;
    localparam logic POL_NEG = 1'b0;

    localparam logic [23:0] BACK_COLOR = 24'h000000;

endpackage

// File: rtl/video_timing_gen.sv
// Free-running raster counter that requests pixels one cycle ahead of the
// active window and registers sync, data enable and pixel for the TMDS encoder.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int unsigned H_SYNC  = H_SYNC_1080,
    parameter int unsigned H_BACK  = H_BACK_1080,
    parameter int unsigned H_DISP  = H_DISP_1080,
    parameter int unsigned H_FRONT = H_FRONT_1080,
    parameter int unsigned V_SYNC  = V_SYNC_1080,
    parameter int unsigned V_BACK  = V_BACK_1080,
    parameter int unsigned V_DISP  = V_DISP_1080,
    parameter int unsigned V_FRONT = V_FRONT_1080,
    parameter logic        HS_POL  = POL_POS,
    parameter logic        VS_POL  = POL_POS
) (
    input  logic        pixel_clk,
    input  logic        sys_rst_n,
    input  logic [23:0] pixel_data,
    output logic [10:0] pixel_xpos,
    output logic [10:0] pixel_ypos,
    output logic        data_req,
    output logic        video_hs,
    output logic        video_vs,
    output logic        video_de,
    output logic [23:0] video_rgb,
    output logic        frame_start
);

    localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
    localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;

    localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);
    localparam logic [11:0] H_SE   = 12'(H_SYNC);
    localparam logic [11:0] V_SE   = 12'(V_SYNC);
    localparam logic [11:0] HA0    = 12'(H_SYNC + H_BACK);
    localparam logic [11:0] HA1    = 12'(H_SYNC + H_BACK + H_DISP);
    localparam logic [11:0] VA0    = 12'(V_SYNC + V_BACK);
    localparam logic [11:0] VA1    = 12'(V_SYNC + V_BACK + V_DISP);
    // Requests run one pixel ahead of de to cover the producer's register.
    localparam logic [11:0] HR0    = 12'(H_SYNC + H_BACK - 1);
    localparam logic [11:0] HR1    = 12'(H_SYNC + H_BACK + H_DISP - 1);

    logic [11:0] h_cnt_q, h_cnt_d;
    logic [11:0] v_cnt_q, v_cnt_d;
    logic        v_act, h_req, de_c, hs_c, vs_c;
    logic        hs_q, vs_q, de_q, fs_q;
    logic [23:0] rgb_q, rgb_d;

    always_comb begin
        h_cnt_d = h_cnt_q + 12'd1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = 12'd0;
            v_cnt_d = (v_cnt_q == V_LAST) ? 12'd0 : v_cnt_q + 12'd1;
        end
    end

    assign v_act = (v_cnt_q >= VA0) && (v_cnt_q < VA1);
    assign h_req = (h_cnt_q >= HR0) && (h_cnt_q < HR1);
    assign de_c  = (h_cnt_q >= HA0) && (h_cnt_q < HA1) && v_act;
    assign hs_c  = (h_cnt_q < H_SE) ? HS_POL : ~HS_POL;
    assign vs_c  = (v_cnt_q < V_SE) ? VS_POL : ~VS_POL;
    assign rgb_d = de_c ? pixel_data : 24'd0;

    assign data_req   = h_req && v_act;
    assign pixel_xpos = data_req ? 11'(h_cnt_q - HR0) : 11'd0;
    assign pixel_ypos = data_req ? 11'(v_cnt_q - VA0) : 11'd0;

    always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            h_cnt_q <= 12'd0;
            v_cnt_q <= 12'd0;
            hs_q    <= ~HS_POL;
            vs_q    <= ~VS_POL;
            de_q    <= 1'b0;
            rgb_q   <= 24'd0;
            fs_q    <= 1'b0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            hs_q    <= hs_c;
            vs_q    <= vs_c;
            de_q    <= de_c;
            rgb_q   <= rgb_d;
            fs_q    <= (h_cnt_q == 12'd0) && (v_cnt_q == 12'd0);
        end
    end

    assign video_hs    = hs_q;
    assign video_vs    = vs_q;
    assign video_de    = de_q;
    assign video_rgb   = rgb_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen at reduced raster size (15x8), both sync polarities,
// with a pixel producer and a scoreboard for video_rgb.
module tb_video_timing_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:0] pdata = 24'hFFFFFF;

    logic [10:0] xp_p, yp_p, xp_n, yp_n;
    logic        req_p, hs_p, vs_p, de_p, fs_p;
    logic        req_n, hs_n, vs_n, de_n, fs_n;
    logic [23:0] rgb_p, rgb_n;

    int n_vec = 0;
    int n_err = 0;
    int n_edges = 0;
    logic [23:0] exp_q[$];

    always #5 clk = ~clk;

    video_timing_gen #(
        .H_SYNC(2), .H_BACK(3), .H_DISP(8), .H_FRONT(2),
        .V_SYNC(1), .V_BACK(2), .V_DISP(4), .V_FRONT(1),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) u_pos (
        .pixel_clk(clk), .sys_rst_n(rst_n), .pixel_data(pdata),
        .pixel_xpos(xp_p), .pixel_ypos(yp_p), .data_req(req_p),
        .video_hs(hs_p), .video_vs(vs_p), .video_de(de_p),
        .video_rgb(rgb_p), .frame_start(fs_p)
    );

    video_timing_gen #(
        .H_SYNC(2), .H_BACK(3), .H_DISP(8), .H_FRONT(2),
        .V_SYNC(1), .V_BACK(2), .V_DISP(4), .V_FRONT(1),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) u_neg (
        .pixel_clk(clk), .sys_rst_n(rst_n), .pixel_data(pdata),
        .pixel_xpos(xp_n), .pixel_ypos(yp_n), .data_req(req_n),
        .video_hs(hs_n), .video_vs(vs_n), .video_de(de_n),
        .video_rgb(rgb_n), .frame_start(fs_n)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s edge=%0d got=%h want=%h", name, n_edges, act, exp);
        end
    endtask

    task automatic push_frames(input int nf);
        for (int f = 0; f < nf; f++)
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 8; c++)
                    exp_q.push_back({8'h00, 8'(r), 8'(c)});
    endtask

    // Producer: returns {0,row,col} one cycle after a request, garbage otherwise.
    initial begin
        logic        r;
        logic [10:0] x, y;
        forever begin
            @(negedge clk);
            r = req_p; x = xp_p; y = yp_p;
            @(posedge clk);
            #1;
            pdata = r ? {8'h00, y[7:0], x[7:0]} : 24'hFFFFFF;
        end
    end

    // Monitor: checks timing against the raster position and pops rgb on de.
    initial begin
        int oh, ov, ch, cv;
        logic e_de, e_req;
        logic [23:0] e_rgb;
        forever begin
            @(posedge clk);
            if (rst_n) n_edges++; else n_edges = 0;
            @(negedge clk);
            if (!rst_n || n_edges == 0) begin
                chk("rst_hs_p", 32'(hs_p), 32'd0);
                chk("rst_vs_p", 32'(vs_p), 32'd0);
                chk("rst_hs_n", 32'(hs_n), 32'd1);
                chk("rst_vs_n", 32'(vs_n), 32'd1);
                chk("rst_de", 32'({de_p, de_n}), 32'd0);
                chk("rst_rgb", 32'(rgb_p | rgb_n), 32'd0);
                chk("rst_fs", 32'({fs_p, fs_n}), 32'd0);
                chk("rst_req", 32'({req_p, req_n}), 32'd0);
            end else begin
                oh = (n_edges - 1) % 15;
                ov = ((n_edges - 1) / 15) % 8;
                ch = n_edges % 15;
                cv = (n_edges / 15) % 8;
                e_de  = (oh >= 5) && (oh <= 12) && (ov >= 3) && (ov <= 6);
                e_req = (ch >= 4) && (ch <= 11) && (cv >= 3) && (cv <= 6);
                chk("hs_p", 32'(hs_p), 32'(oh < 2));
                chk("vs_p", 32'(vs_p), 32'(ov < 1));
                chk("hs_n", 32'(hs_n), 32'(!(oh < 2)));
                chk("vs_n", 32'(vs_n), 32'(!(ov < 1)));
                chk("de_p", 32'(de_p), 32'(e_de));
                chk("de_n", 32'(de_n), 32'(e_de));
                chk("fs", 32'({fs_p, fs_n}), (oh == 0 && ov == 0) ? 32'd3 : 32'd0);
                chk("req", 32'({req_p, req_n}), e_req ? 32'd3 : 32'd0);
                chk("xpos", 32'({xp_p, xp_n}), e_req ? 32'({11'(ch - 4), 11'(ch - 4)}) : 32'd0);
                chk("ypos", 32'({yp_p, yp_n}), e_req ? 32'({11'(cv - 3), 11'(cv - 3)}) : 32'd0);
                if (de_p) begin
                    if (exp_q.size() == 0) begin
                        chk("rgb_q_empty", 32'(exp_q.size()), 32'd1);
                    end else begin
                        e_rgb = exp_q.pop_front();
                        chk("rgb_p", 32'(rgb_p), 32'(e_rgb));
                        chk("rgb_n", 32'(rgb_n), 32'(e_rgb));
                    end
                end else begin
                    chk("rgb_idle", 32'(rgb_p | rgb_n), 32'd0);
                end
            end
        end
    end

    initial begin
        int w;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        push_frames(3);
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (250) @(posedge clk);

        // Find an active output line, go a few pixels in, then reset mid-line.
        w = 0;
        while (w < 200) begin
            @(posedge clk);
            #2;
            if (de_p) break;
            w++;
        end
        if (w == 200) chk("wait_de", 32'(w), 32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_de", 32'({de_p, de_n}), 32'd0);
        chk("async_rgb", 32'(rgb_p | rgb_n), 32'd0);
        chk("async_sync_p", 32'({hs_p, vs_p}), 32'd0);
        chk("async_sync_n", 32'({hs_n, vs_n}), 32'd3);
        exp_q.delete();
        repeat (3) @(posedge clk);
        push_frames(2);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("fs_after_release", 32'(fs_p), 32'd1);
        repeat (244) @(posedge clk);
        #1;
        chk("rgb_q_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
